// File: rtl/pc_mux.sv
// Next-PC select mux for instruction fetch: combinational PC+4 / branch-target
// select, plus a registered copy of the selection and a saturating redirect counter.
module pc_mux #(
  parameter int WIDTH     = 8,
  parameter int IN1_WIDTH = 32,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     in0,
  input  logic [IN1_WIDTH-1:0] in1,
  input  logic                 sel,
  output logic [WIDTH-1:0]     out,
  output logic [WIDTH-1:0]     out_q,
  output logic                 sel_q,
  output logic [CNT_WIDTH-1:0] redirect_count
);

  logic [CNT_WIDTH-1:0] cnt_d;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt);
    if (&cnt) begin
      sat_inc = cnt;
    end else begin
      sat_inc = cnt + 1'b1;
    end
  endfunction

  // Branch targets wider than the PC are truncated; the upper bits are dropped.
  assign out = sel ? in1[WIDTH-1:0] : in0;

  generate
    if (IN1_WIDTH > WIDTH) begin : g_in1_hi
      logic unused_in1_hi;
      assign unused_in1_hi = ^in1[IN1_WIDTH-1:WIDTH];
    end
  endgenerate

  always_comb begin
    cnt_d = redirect_count;
    if (sel) begin
      cnt_d = sat_inc(redirect_count);
    end
  end

  // Stage boundary: debug/perf copies of the selection, one cycle behind out.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_q          <= '0;
      sel_q          <= 1'b0;
      redirect_count <= '0;
    end else begin
      out_q          <= out;
      sel_q          <= sel;
      redirect_count <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pc_mux.sv
// Bench for pc_mux: vector table, directed reset/saturation/fetch sequences and
// randomized traffic against a behavioural model of the select and counter.
module tb_pc_mux;

  localparam int W  = 8;
  localparam int W1 = 32;
  localparam int CW = 8;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clock;
  logic          reset;
  logic [W-1:0]  in0;
  logic [W1-1:0] in1;
  logic          sel;
  logic [W-1:0]  out;
  logic [W-1:0]  out_q;
  logic          sel_q;
  logic [CW-1:0] redirect_count;

  pc_mux #(.WIDTH(W), .IN1_WIDTH(W1), .CNT_WIDTH(CW)) dut (
    .clock          (clock),
    .reset          (reset),
    .in0            (in0),
    .in1            (in1),
    .sel            (sel),
    .out            (out),
    .out_q          (out_q),
    .sel_q          (sel_q),
    .redirect_count (redirect_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  int m_outq = 0;
  int m_selq = 0;
  int m_cnt  = 0;

  typedef struct {
    logic          s;
    logic [W-1:0]  a;
    logic [W1-1:0] b;
    logic [W-1:0]  exp_out;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int model_out(input logic s, input logic [W-1:0] a, input logic [W1-1:0] b);
    if (s) return int'(b % (64'd1 << W));
    return int'(a);
  endfunction

  task automatic model_reset();
    m_outq = 0;
    m_selq = 0;
    m_cnt  = 0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".out_q"}, out_q, m_outq);
    check({tag, ".sel_q"}, sel_q, m_selq);
    check({tag, ".redirect_count"}, redirect_count, m_cnt);
  endtask

  // One rising edge; model samples the inputs present at the edge.
  task automatic tick(input string tag);
    @(posedge clock);
    if (!reset) begin
      m_outq = model_out(sel, in0, in1);
      m_selq = sel;
      if (sel && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end
    #1;
    check_regs(tag);
  endtask

  task automatic drive(input logic s, input logic [W-1:0] a, input logic [W1-1:0] b);
    sel = s;
    in0 = a;
    in1 = b;
    #1;
    check("out", out, model_out(s, a, b));
  endtask

  initial begin
    reset = 1'b1;
    sel   = 1'b0;
    in0   = 8'h04;
    in1   = 32'h0000_0020;

    vecs[0] = '{1'b0, 8'h04, 32'h0000_0020, 8'h04};
    vecs[1] = '{1'b1, 8'h04, 32'h0000_0020, 8'h20};
    vecs[2] = '{1'b1, 8'h10, 32'hDEAD_BE3C, 8'h3C};
    vecs[3] = '{1'b0, 8'hFF, 32'hFFFF_FFFF, 8'hFF};
    vecs[4] = '{1'b1, 8'hAA, 32'h1234_5600, 8'h00};
    vecs[5] = '{1'b0, 8'h00, 32'hFFFF_FF11, 8'h00};

    // Reset state, with out still live during reset
    #2;
    check_regs("reset");
    check("out_in_reset", out, 8'h04);
    tick("reset_hold");
    #2 reset = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 6; i++) begin
      sel = vecs[i].s;
      in0 = vecs[i].a;
      in1 = vecs[i].b;
      #1;
      check($sformatf("vec%0d.out", i), out, vecs[i].exp_out);
      tick($sformatf("vec%0d", i));
    end

    // Async reset mid-cycle after 3 redirects from a cleared counter
    @(negedge clock);
    reset = 1'b1;
    #1 reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h04, 32'h0000_0040 + i);
      tick("redir");
    end
    check("redir3.count", redirect_count, 3);
    #2 reset = 1'b1;
    #1;
    check("async.out_q", out_q, 0);
    check("async.sel_q", sel_q, 0);
    check("async.count", redirect_count, 0);
    check("async.out", out, 8'h42);
    in0 = 8'h5C;
    sel = 1'b0;
    #1;
    check("async.out_follow", out, 8'h5C);
    #1 reset = 1'b0;
    model_reset();
    tick("post_reset");

    // Saturation
    drive(1'b1, 8'h00, 32'h0000_0080);
    for (int i = 0; i < 300; i++) tick("sat_up");
    check("sat.count", redirect_count, 8'hFF);
    drive(1'b0, 8'h08, 32'h0000_0080);
    for (int i = 0; i < 5; i++) tick("sat_hold");
    check("sat_hold.count", redirect_count, 8'hFF);

    // Fetch sequence: PC+4 loop, one-cycle redirect, then sequential resumes
    begin
      int pc;
      pc = 0;
      for (int i = 0; i < 3; i++) begin
        drive(1'b0, W'(pc + 4), 32'h0);
        check($sformatf("fetch%0d.out", i), out, pc + 4);
        tick("fetch");
        pc = int'(out_q);
      end
      check("fetch.pc", pc, 12);
      drive(1'b1, W'(pc + 4), 32'h0000_0040);
      tick("fetch_br");
      check("fetch_br.out_q", out_q, 8'h40);
      pc = int'(out_q);
      drive(1'b0, W'(pc + 4), 32'h0000_0040);
      tick("fetch_resume");
      check("fetch_resume.out_q", out_q, 8'h44);
    end

    // Randomized traffic with occasional async pulses and held resets
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 24);
      drive(1'($urandom_range(0, 1)), W'($urandom), W1'($urandom));
      if (r == 0) begin
        #1 reset = 1'b1;
        model_reset();
        #1;
        check_regs("rnd_pulse");
        reset = 1'b0;
      end else if (r == 1) begin
        reset = 1'b1;
        model_reset();
      end
      tick("rnd");
      reset = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pc_mux.md
# pc_mux

Next-PC select multiplexer for the instruction-fetch stage. It chooses between the sequential address (PC+4) and the branch/jump target from EX/MEM, driving the PC register input combinationally. It also provides a registered copy of the selection and a saturating redirect counter for debug and performance visibility.

## Interface
- WIDTH, 8: width of `in0` and `out` (PC width).
- IN1_WIDTH, 32: width of `in1` (branch target bus); must be >= WIDTH.
- CNT_WIDTH, 8: width of `redirect_count`.

- clock  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in0  input  WIDTH  sequential next PC (PC+4).
- in1  input  IN1_WIDTH  branch/jump target from EX/MEM.
- sel  input  1  PCSrc: 0 selects `in0`, 1 selects `in1`.
- out  output  WIDTH  selected next PC, combinational.
- out_q  output  WIDTH  `out` registered on each rising edge.
- sel_q  output  1  `sel` registered on each rising edge.
- redirect_count  output  CNT_WIDTH  count of clock edges sampled with `sel`=1, saturating.

## Operation
- `out` = `sel` ? `in1[WIDTH-1:0]` : `in0`. Upper bits `in1[IN1_WIDTH-1:WIDTH]` are ignored (truncation, no error flag).
- `out` is purely combinational. It does not depend on `clock` or `reset`; it stays valid during reset.
- `sel` of X/Z is not supported. `out` behaviour for it is simulator-defined and is not checked.
- On each rising `clock` with `reset` low:
  - `out_q` <= `out`.
  - `sel_q` <= `sel`.
  - if `sel`=1 and `redirect_count` < all-ones, `redirect_count` increments by 1. At all-ones it holds (saturates, no wrap).
- No enable and no handshake. Every edge samples.

## Timing
- `out`: zero-cycle latency from `in0`/`in1`/`sel`. The upstream PC register captures it on the same edge.
- `out_q`, `sel_q`, `redirect_count`: 1-cycle latency, updated on the rising edge.
- `reset` assertion immediately clears `out_q`, `sel_q` and `redirect_count` to 0, independent of `clock`.
- While `reset` is high, these registers hold 0.
- First update after release is on the first rising edge with `reset` low.
- Reset asserted mid-operation (for example while `sel`=1) clears the counter at once. No partial increment is retained.
- Simultaneous `sel` change and clock edge: the value present at the edge (setup satisfied) is the one sampled.

## Test plan
- Select sequential path: `in0`=8'h04, `in1`=32'h0000_0020, `sel`=0 -> `out`=8'h04 immediately. After the next edge, `out_q`=8'h04 and `redirect_count`=0.
- Select branch target: `sel`=1, `in1`=32'h0000_0020 -> `out`=8'h20 combinationally. After the edge, `out_q`=8'h20, `sel_q`=1, `redirect_count`=1.
- Truncation: `sel`=1, `in1`=32'hDEAD_BE3C -> `out`=8'h3C.
- Async reset: after 3 redirect edges (`redirect_count`=3), pulse `reset` between edges -> `out_q`, `sel_q`, `redirect_count` go to 0 without a clock edge. `out` still follows the inputs throughout.
- Saturation: hold `sel`=1 for 300 edges -> `redirect_count` reaches 8'hFF and holds there. Then `sel`=0 for 5 edges -> `redirect_count` stays 8'hFF.
- Fetch sequence: `in0` = PC+4 loop starting at PC=0 with `sel`=0 -> `out` steps 4, 8, 12. Assert `sel`=1 with `in1`=0x40 for one cycle -> next `out_q`=0x40, after which the sequential path resumes.
